// File: rtl/waveform_output_stage_pkg.sv
// waveform_pkg: shared FSM state, config record and arithmetic helpers for the output stage
package waveform_pkg;
  localparam int CFG_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, PENDING} state_t;
  typedef struct packed {
    logic [CFG_W-1:0] src_sel;
    logic [CFG_W-1:0] gain;
    logic [CFG_W-1:0] offset;
  } cfg_t;
  function automatic logic [CFG_W-1:0] unity_gain(input int gain_width);
    return CFG_W'(1) << (gain_width - 1);
  endfunction
  // bit 32 flags that the sum was clamped to 2^width-1
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << width) - 33'd1;
    return (sum > lim) ? {1'b1, lim[31:0]} : {1'b0, sum[31:0]};
  endfunction
endpackage

// File: rtl/waveform_output_stage_if.sv
// waveform_output_stage_if: control, source and output bundle of the waveform output stage
interface waveform_output_stage_if #(
  parameter int WIDTH = 8,
  parameter int NUM_SRC = 4,
  parameter int GAIN_WIDTH = 8
);
  localparam int SEL_W = $clog2(NUM_SRC);
  logic enable;
  logic sample_tick;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [SEL_W-1:0] cfg_src_sel;
  logic [GAIN_WIDTH-1:0] cfg_gain;
  logic [WIDTH-1:0] cfg_offset;
  logic cfg_load;
  logic cfg_busy;
  logic [WIDTH-1:0] duty_cycle;
  logic [WIDTH-1:0] R2R_out;
  logic out_valid;
  logic sat_flag;
  modport master (
    output enable, sample_tick, src_data, cfg_src_sel, cfg_gain, cfg_offset, cfg_load,
    input cfg_busy, duty_cycle, R2R_out, out_valid, sat_flag
  );
  modport slave (
    input enable, sample_tick, src_data, cfg_src_sel, cfg_gain, cfg_offset, cfg_load,
    output cfg_busy, duty_cycle, R2R_out, out_valid, sat_flag
  );
endinterface

// File: rtl/waveform_output_stage_gain_offset_sat.sv
// gain_offset_sat: second pipeline stage; scales by gain (unity = 2^(GAIN_WIDTH-1)), adds offset, clamps
module gain_offset_sat
  import waveform_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAIN_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  in_vld,
  input  logic [WIDTH-1:0]      sample,
  input  logic [GAIN_WIDTH-1:0] gain,
  input  logic [WIDTH-1:0]      offset,
  output logic [WIDTH-1:0]      duty,
  output logic                  out_vld,
  output logic                  sat_hit
);
  localparam int PW = WIDTH + GAIN_WIDTH;
  logic [PW-1:0] prod, scaled;
  logic sat;
  logic [32-WIDTH-1:0] hi_unused;
  logic [WIDTH-1:0] val;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic vld_q, vld_d;
  always_comb begin
    prod = PW'(sample) * PW'(gain);
    scaled = prod >> (GAIN_WIDTH - 1);
    {sat, hi_unused, val} = sat_add(32'(scaled), 32'(offset), WIDTH);
    sat_hit = in_vld && !clr && sat;
    vld_d = in_vld && !clr;
    duty_d = clr ? '0 : in_vld ? val : duty_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      duty_q <= '0;
      vld_q <= 1'b0;
    end else begin
      duty_q <= duty_d;
      vld_q <= vld_d;
    end
  assign duty = duty_q;
  assign out_vld = vld_q;
endmodule

// File: rtl/waveform_output_stage.sv
// waveform_output_stage: source select, gain/offset/saturation and double-buffered config
// that switches only at a selected-source zero crossing or after a tick timeout.
module waveform_output_stage
  import waveform_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NUM_SRC = 4,
  parameter int GAIN_WIDTH = 8,
  parameter int SWITCH_TIMEOUT = 1024
) (
  input logic clk,
  input logic reset,
  waveform_output_stage_if.slave bus
);
  localparam int CNT_W = $clog2(SWITCH_TIMEOUT + 1);
  localparam cfg_t CFG_RST = '{src_sel: '0, gain: unity_gain(GAIN_WIDTH), offset: '0};
  state_t state_q, state_d;
  cfg_t act_q, act_d, shd_q, shd_d, eff, req;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic busy_q, busy_d, sat_q, sat_d;
  logic [WIDTH-1:0] s1_q, s1_d, o1_q, o1_d;
  logic [GAIN_WIDTH-1:0] g1_q, g1_d;
  logic v1_q, v1_d;
  logic run, safe, sat_hit, out_vld, cfg_unused;
  logic [WIDTH-1:0] raw_act, duty;
  function automatic logic [WIDTH-1:0] pick(input logic [NUM_SRC*WIDTH-1:0] data, input logic [CFG_W-1:0] sel);
    int idx;
    idx = (sel < CFG_W'(NUM_SRC)) ? int'(sel) : 0;
    return data[idx*WIDTH +: WIDTH];
  endfunction
  always_comb begin
    run = bus.enable && state_q != IDLE;
    req = '{src_sel: CFG_W'(bus.cfg_src_sel), gain: CFG_W'(bus.cfg_gain), offset: CFG_W'(bus.cfg_offset)};
    raw_act = pick(bus.src_data, act_q.src_sel);
    safe = state_q == PENDING && bus.sample_tick &&
           (raw_act == '0 || tcnt_q == CNT_W'(SWITCH_TIMEOUT - 1));
    eff = safe ? shd_q : act_q;
    state_d = state_q;
    act_d = act_q;
    shd_d = shd_q;
    tcnt_d = tcnt_q;
    busy_d = busy_q;
    sat_d = bus.cfg_load ? 1'b0 : sat_q | sat_hit;
    // Output is silent while disabled, so any pending shadow can take effect at once.
    if (!bus.enable || state_q == IDLE) begin
      state_d = bus.enable ? RUN : IDLE;
      act_d = bus.cfg_load ? req : (state_q == PENDING) ? shd_q : act_q;
      shd_d = act_d;
      busy_d = 1'b0;
    end else begin
      if (safe) begin
        act_d = shd_q;
        state_d = RUN;
        busy_d = 1'b0;
      end else if (bus.sample_tick) begin
        tcnt_d = tcnt_q + CNT_W'(1);
      end
      if (bus.cfg_load) begin
        shd_d = req;
        tcnt_d = '0;
        busy_d = 1'b1;
        state_d = PENDING;
      end
    end
    v1_d = run && bus.sample_tick;
    s1_d = v1_d ? pick(bus.src_data, eff.src_sel) : s1_q;
    g1_d = v1_d ? eff.gain[GAIN_WIDTH-1:0] : g1_q;
    o1_d = v1_d ? eff.offset[WIDTH-1:0] : o1_q;
  end
  assign cfg_unused = ^{eff.gain, eff.offset};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      act_q <= CFG_RST;
      shd_q <= CFG_RST;
      tcnt_q <= '0;
      busy_q <= 1'b0;
      sat_q <= 1'b0;
      s1_q <= '0;
      g1_q <= '0;
      o1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q <= act_d;
      shd_q <= shd_d;
      tcnt_q <= tcnt_d;
      busy_q <= busy_d;
      sat_q <= sat_d;
      s1_q <= s1_d;
      g1_q <= g1_d;
      o1_q <= o1_d;
      v1_q <= v1_d;
    end
  gain_offset_sat #(.WIDTH(WIDTH), .GAIN_WIDTH(GAIN_WIDTH)) u_gos (
    .clk(clk),
    .reset(reset),
    .clr(!run),
    .in_vld(v1_q),
    .sample(s1_q),
    .gain(g1_q),
    .offset(o1_q),
    .duty(duty),
    .out_vld(out_vld),
    .sat_hit(sat_hit)
  );
  assign bus.duty_cycle = duty;
  assign bus.R2R_out = duty;
  assign bus.out_valid = out_vld;
  assign bus.cfg_busy = busy_q;
  assign bus.sat_flag = sat_q;
endmodule

// File: tb/tb_waveform_output_stage.sv
// tb_waveform_output_stage: scoreboard bench; expected samples queued at each tick, matched on out_valid
module tb_waveform_output_stage;
  localparam int W = 8, N = 4, G = 8, TO = 8;
  typedef struct {
    logic [W-1:0] val;
    int due;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  waveform_output_stage_if #(.WIDTH(W), .NUM_SRC(N), .GAIN_WIDTH(G)) bus ();
  waveform_output_stage #(.WIDTH(W), .NUM_SRC(N), .GAIN_WIDTH(G), .SWITCH_TIMEOUT(TO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  function automatic logic [W-1:0] model(input int s, input int g, input int o);
    int r;
    r = ((s * g) >> 7) + o;
    return (r > 255) ? 8'd255 : W'(r);
  endfunction
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.out_valid) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: out_valid=1 duty=%0d at cycle %0d, none expected", bus.duty_cycle, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.duty_cycle !== e.val || bus.R2R_out !== e.val || cyc != e.due) begin
          n_fail++;
          $display("FAIL out_value: duty=%0d r2r=%0d at cycle %0d, expected %0d at cycle %0d",
                   bus.duty_cycle, bus.R2R_out, cyc, e.val, e.due);
        end
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      n_chk++;
      n_fail++;
      e = sb.pop_front();
      $display("FAIL out_missing: out_valid=0 at cycle %0d, expected %0d", cyc, e.val);
    end
  endtask
  task automatic set_src(input int i, input int v);
    bus.src_data[i*W +: W] = W'(v);
  endtask
  task automatic tick(input int e);
    sb.push_back('{val: W'(e), due: cyc + 2});
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
  endtask
  task automatic set_cfg(input int sel, input int g, input int o);
    bus.cfg_src_sel = 2'(sel);
    bus.cfg_gain = G'(g);
    bus.cfg_offset = W'(o);
  endtask
  task automatic load_cfg(input int sel, input int g, input int o);
    set_cfg(sel, g, o);
    bus.cfg_load = 1'b1;
    step();
    bus.cfg_load = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 6 && sb.size() != 0; i++) step();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d outputs still outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask
  task automatic test_reset();
    bus.enable = 1'b1;
    repeat (2) step();
    n_chk++;
    if (bus.duty_cycle !== 8'd0 || bus.cfg_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: duty=%0d busy=%0d, expected 0 0", bus.duty_cycle, bus.cfg_busy);
    end
    reset = 1'b0;
    step();
    set_src(0, 77);
    set_src(1, 33);
    tick(77);
    drain();
    load_cfg(1, 128, 0);
    n_chk++;
    if (bus.cfg_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_before_reset: got %0d, expected 1", bus.cfg_busy);
    end
    #3 reset = 1'b1;
    #1;
    n_chk++;
    if (bus.duty_cycle !== 8'd0 || bus.R2R_out !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_duty: duty=%0d r2r=%0d, expected 0", bus.duty_cycle, bus.R2R_out);
    end
    n_chk++;
    if (bus.cfg_busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%0d valid=%0d sat=%0d, expected 0 0 0", bus.cfg_busy, bus.out_valid, bus.sat_flag);
    end
    step();
    reset = 1'b0;
    step();
    set_src(0, 100);
    tick(100);
    step();
    step();
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_pulse: out_valid=%0d one cycle after output, expected 0", bus.out_valid);
    end
  endtask
  task automatic test_back_to_back();
    for (int v = 1; v <= 5; v++) begin
      set_src(0, v * 40);
      tick(v * 40);
    end
    drain();
  endtask
  task automatic test_gain_offset();
    bus.enable = 1'b0;
    step();
    load_cfg(0, 64, 10);
    n_chk++;
    if (bus.cfg_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_load_busy: got %0d, expected 0", bus.cfg_busy);
    end
    bus.enable = 1'b1;
    step();
    set_src(0, 200);
    tick(model(200, 64, 10));
    drain();
    n_chk++;
    if (bus.sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clear: got %0d, expected 0", bus.sat_flag);
    end
    bus.enable = 1'b0;
    step();
    load_cfg(0, 255, 0);
    bus.enable = 1'b1;
    step();
    tick(255);
    drain();
    n_chk++;
    if (bus.sat_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_set: got %0d, expected 1", bus.sat_flag);
    end
    load_cfg(0, 128, 0);
    n_chk++;
    if (bus.sat_flag !== 1'b0 || bus.cfg_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_clears_sat: sat=%0d busy=%0d, expected 0 1", bus.sat_flag, bus.cfg_busy);
    end
    set_src(0, 0);
    tick(0);
    n_chk++;
    if (bus.cfg_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_zero: got %0d, expected 0", bus.cfg_busy);
    end
    drain();
  endtask
  task automatic test_safe_switch();
    set_src(1, 60);
    set_src(0, 5);
    set_cfg(1, 128, 0);
    bus.cfg_load = 1'b1;
    tick(5);
    bus.cfg_load = 1'b0;
    for (int v = 4; v >= 0; v--) begin
      set_src(0, v);
      n_chk++;
      if (bus.cfg_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL safe_busy_hold: got %0d before sample %0d, expected 1", bus.cfg_busy, v);
      end
      tick(v == 0 ? 60 : v);
    end
    n_chk++;
    if (bus.cfg_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL safe_busy_drop: got %0d, expected 0", bus.cfg_busy);
    end
    set_src(0, 9);
    tick(60);
    drain();
  endtask
  task automatic test_timeout();
    set_src(1, 50);
    set_src(2, 20);
    load_cfg(2, 128, 0);
    for (int k = 1; k <= TO; k++) begin
      n_chk++;
      if (bus.cfg_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout_busy: got %0d before tick %0d, expected 1", bus.cfg_busy, k);
      end
      tick(k == TO ? 20 : 50);
    end
    n_chk++;
    if (bus.cfg_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_done: busy=%0d, expected 0", bus.cfg_busy);
    end
    drain();
  endtask
  task automatic test_reload();
    set_src(3, 100);
    load_cfg(3, 128, 0);
    repeat (3) tick(20);
    load_cfg(3, 32, 0);
    for (int k = 1; k <= TO; k++) begin
      n_chk++;
      if (bus.cfg_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL reload_busy: got %0d before tick %0d, expected 1", bus.cfg_busy, k);
      end
      tick(k == TO ? model(100, 32, 0) : 20);
    end
    n_chk++;
    if (bus.cfg_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_done: busy=%0d, expected 0", bus.cfg_busy);
    end
    drain();
  endtask
  task automatic test_disable();
    load_cfg(0, 64, 10);
    set_src(0, 200);
    tick(model(100, 32, 0));
    drain();
    n_chk++;
    if (bus.cfg_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL disable_pending: busy=%0d, expected 1", bus.cfg_busy);
    end
    bus.enable = 1'b0;
    step();
    n_chk++;
    if (bus.cfg_busy !== 1'b0 || bus.duty_cycle !== 8'd0) begin
      n_fail++;
      $display("FAIL disable_silent: busy=%0d duty=%0d, expected 0 0", bus.cfg_busy, bus.duty_cycle);
    end
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    repeat (2) step();
    bus.enable = 1'b1;
    step();
    tick(model(200, 64, 10));
    drain();
  endtask
  initial begin
    bus.enable = 1'b0;
    bus.sample_tick = 1'b0;
    bus.src_data = '0;
    bus.cfg_src_sel = '0;
    bus.cfg_gain = '0;
    bus.cfg_offset = '0;
    bus.cfg_load = 1'b0;
    test_reset();
    test_back_to_back();
    test_gain_offset();
    test_safe_switch();
    test_timeout();
    test_reload();
    test_disable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/waveform_output_stage.md
Name: waveform_output_stage

Overview:
- Downstream conditioning stage between the waveform generators (triangle and siblings) and the PWM/R2R outputs.
- Selects one of NUM_SRC raw duty/sample buses, applies gain and offset with saturation, and drives the PWM duty_cycle and R2R ladder.
- Configuration changes (source, gain, offset) are double-buffered and applied only at a glitch-free point: a selected-source minimum, or a timeout.

Parameters:
- WIDTH, 8, sample/duty bit width.
- NUM_SRC, 4, number of waveform source buses (≥2).
- GAIN_WIDTH, 8, gain bit width; unity = 2^(GAIN_WIDTH-1).
- SWITCH_TIMEOUT, 1024, max sample_ticks a pending config waits for a safe point.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  active-high enable; low = silent output.
- sample_tick  in  1  one-cycle strobe; sources hold new samples this cycle.
- src_data  in  NUM_SRC*WIDTH  packed source samples; source i at [i*WIDTH +: WIDTH].
- cfg_src_sel  in  $clog2(NUM_SRC)  requested source.
- cfg_gain  in  GAIN_WIDTH  requested gain.
- cfg_offset  in  WIDTH  requested unsigned offset.
- cfg_load  in  1  one-cycle strobe; captures cfg_* into shadow registers.
- cfg_busy  out  1  high while a shadow config is pending.
- duty_cycle  out  WIDTH  conditioned sample to PWM.
- R2R_out  out  WIDTH  identical to duty_cycle.
- out_valid  out  1  one-cycle pulse when duty_cycle updates.
- sat_flag  out  1  sticky; set when saturation occurred, cleared by cfg_load.

Behaviour:
- Reset values (async):
  - duty_cycle, R2R_out, out_valid, cfg_busy, sat_flag = 0.
  - Active config = src 0, gain unity (128 at default), offset 0.
  - Shadow config = active config.
  - FSM = IDLE.
- Pipeline, two stages, both advancing only on sample_tick-derived valid:
  - S1 (cycle t, sample_tick=1): register the selected source sample using the active config.
  - S2 (t+1): prod = s1 * gain, full 2*WIDTH+ width; scaled = prod >> (GAIN_WIDTH-1); sum = scaled + offset; if sum > 2^WIDTH-1, output = 2^WIDTH-1 and sat_flag <= 1.
  - Result is visible on duty_cycle at t+2, with out_valid=1 that cycle only. Latency is exactly 2 clk.
  - Back-to-back ticks on consecutive cycles must be supported at full throughput.
- FSM states IDLE, RUN, PENDING:
  - IDLE: duty_cycle forced 0, out_valid 0, pipeline valids cleared. enable=1 → RUN next cycle.
  - RUN: cfg_load → capture shadow, cfg_busy=1, clear sat_flag, timeout counter=0, go to PENDING.
  - PENDING, on sample_tick where the raw sample of the currently active source == 0, or timeout counter reaches SWITCH_TIMEOUT-1:
    - copy shadow → active for that tick's S1 capture (new config applies to that sample).
    - cfg_busy=0, go to RUN.
  - PENDING, otherwise: each sample_tick increments the timeout counter.
  - PENDING with cfg_load again: overwrite shadow, reset timeout counter, stay PENDING.
  - Any state with enable=0: go to IDLE. A pending shadow is applied to active immediately (output is silent), cfg_busy=0.
  - cfg_load in IDLE: shadow and active both loaded directly, cfg_busy stays 0.
- Simultaneous events:
  - cfg_load and a safe-point tick in the same cycle: the safe point uses the old shadow; the new load then starts a fresh PENDING.
  - cfg_load with enable=0 in the same cycle: treated as an IDLE load.
- An out-of-range cfg_src_sel (≥NUM_SRC) selects source 0.
- Async reset mid-PENDING discards the shadow and returns to reset values.

Decomposition:
- Package waveform_pkg holds:
  - state enum state_t {IDLE, RUN, PENDING}.
  - cfg_t struct {src_sel, gain, offset}.
  - function unity_gain(GAIN_WIDTH).
  - saturating add function.
- One sub-module: gain_offset_sat (S2 arithmetic plus saturation, registered output), instantiated once.

Test Plan:
- Reset values: assert reset async mid-cycle → all outputs 0, sources select 0. Then enable, ticks with src0=8'd100 → duty_cycle=100 exactly 2 clk after each tick, out_valid one-cycle.
- Gain/offset math: gain=64, offset=10, src=200 → 110. gain=255, src=200, offset=0 → 398 saturates to 255, sat_flag=1. A following cfg_load clears sat_flag.
- Safe-point switch: active src0 ramping 5,4,3,2,1,0; cfg_load src_sel=1 at sample 5 → cfg_busy=1 until the tick where src0=0. That tick outputs the src1 value; cfg_busy drops that cycle.
- Timeout: SWITCH_TIMEOUT=8, src0 held at 50, cfg_load → switch occurs on the 8th tick; cfg_busy high for exactly 8 ticks.
- Re-load while pending: second cfg_load (gain=32) during PENDING → the final applied config is the second one, and the timeout restarts.
- Disable mid-pending: enable=0 during PENDING → cfg_busy=0 next cycle, duty_cycle=0. Re-enable → the first output uses the new config.
